// File: rtl/switch_crossbar_sched.sv
// Packet-level grant scheduler: one round-robin arbiter per output, locked until tlast.
// Optional idle-beat forced release is compiled in with SWITCH_SCHED_TIMEOUT_EN.
module switch_crossbar_sched #(
  parameter int unsigned RADIX     = 4,
  parameter int unsigned IDX_WIDTH = (RADIX > 1) ? $clog2(RADIX) : 1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [RADIX-1:0]               s_valid,
  input  logic [RADIX*RADIX-1:0]         s_dest,
  input  logic [RADIX-1:0]               s_ready,
  input  logic [RADIX-1:0]               s_last,
  output logic [RADIX*RADIX-1:0]         grant,
  output logic [RADIX-1:0]               grant_valid,
  output logic [RADIX*IDX_WIDTH-1:0]     grant_idx,
  output logic [RADIX-1:0]               dest_err,
  output logic [RADIX-1:0]               timeout
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [RADIX-1:0]     state_q, state_d;
  logic [RADIX-1:0]     grant_q [RADIX];
  logic [RADIX-1:0]     grant_d [RADIX];
  logic [IDX_WIDTH-1:0] idx_q [RADIX];
  logic [IDX_WIDTH-1:0] idx_d [RADIX];
  logic [IDX_WIDTH-1:0] ptr_q [RADIX];
  logic [IDX_WIDTH-1:0] ptr_d [RADIX];
  logic [RADIX-1:0]     dest_err_q, dest_err_d;

  logic [RADIX-1:0]     dest_oh;
  logic [RADIX-1:0]     beat;
  logic [RADIX-1:0]     req [RADIX];   // req[o][i]
  logic [RADIX-1:0]     release_o;
  logic [RADIX-1:0]     busy;
  logic [RADIX-1:0]     rel_in;

`ifdef SWITCH_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] cnt_q [RADIX];
  logic [CntW-1:0] cnt_d [RADIX];
  logic [RADIX-1:0] timeout_q, timeout_d;
`endif

  // Request decode, per-output release and the cross-output lock mask.
  always_comb begin
    beat       = s_valid & s_ready;
    dest_err_d = '0;
    busy       = '0;
    rel_in     = '0;
    release_o  = '0;
    for (int i = 0; i < int'(RADIX); i++) begin
      dest_oh[i]    = ($countones(s_dest[i*RADIX +: RADIX]) == 1);
      dest_err_d[i] = s_valid[i] && (s_dest[i*RADIX +: RADIX] != '0) && !dest_oh[i];
    end
    for (int o = 0; o < int'(RADIX); o++) begin
      for (int i = 0; i < int'(RADIX); i++) begin
        req[o][i] = s_valid[i] & s_dest[i*RADIX+o] & dest_oh[i];
      end
      release_o[o] = (state_q[o] == StLocked) && |(grant_q[o] & beat & s_last);
      busy         = busy | grant_q[o];
      if (release_o[o]) rel_in = rel_in | grant_q[o];
    end
  end

  always_comb begin
    logic [RADIX-1:0] elig;
    logic             found;
    logic             forced;
    int               win;
    int               cand;
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef SWITCH_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = '0;
`endif
    for (int o = 0; o < int'(RADIX); o++) begin
      forced = 1'b0;
`ifdef SWITCH_SCHED_TIMEOUT_EN
      if (state_q[o] == StLocked) begin
        if (|(grant_q[o] & beat)) begin
          cnt_d[o] = '0;
        end else if (cnt_q[o] == CntMax) begin
          forced = 1'b1;
        end else begin
          cnt_d[o] = cnt_q[o] + CntW'(1);
        end
      end else begin
        cnt_d[o] = '0;
      end
      timeout_d[o] = forced;
`endif
      // Inputs locked elsewhere are masked unless that lock drops on this edge.
      elig = req[o] & ~(busy & ~rel_in);
      if (release_o[o]) elig = elig & ~grant_q[o];
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < int'(RADIX); k++) begin
        cand = (int'(ptr_q[o]) + k) % int'(RADIX);
        if (!found && elig[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (forced) begin
        state_d[o] = StIdle;
        grant_d[o] = '0;
        idx_d[o]   = '0;
      end else if ((state_q[o] == StIdle) || release_o[o]) begin
        if (found) begin
          state_d[o]      = StLocked;
          grant_d[o]      = '0;
          grant_d[o][win] = 1'b1;
          idx_d[o]        = IDX_WIDTH'(win);
          ptr_d[o]        = IDX_WIDTH'((win + 1) % int'(RADIX));
`ifdef SWITCH_SCHED_TIMEOUT_EN
          cnt_d[o]        = '0;
`endif
        end else begin
          state_d[o] = StIdle;
          grant_d[o] = '0;
          idx_d[o]   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= '0;
      dest_err_q <= '0;
      for (int o = 0; o < int'(RADIX); o++) begin
        grant_q[o] <= '0;
        idx_q[o]   <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      dest_err_q <= dest_err_d;
      for (int o = 0; o < int'(RADIX); o++) begin
        grant_q[o] <= grant_d[o];
        idx_q[o]   <= idx_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

`ifdef SWITCH_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= '0;
      for (int o = 0; o < int'(RADIX); o++) cnt_q[o] <= '0;
    end else begin
      timeout_q <= timeout_d;
      for (int o = 0; o < int'(RADIX); o++) cnt_q[o] <= cnt_d[o];
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = '0;
`endif

  always_comb begin
    grant       = '0;
    grant_valid = '0;
    grant_idx   = '0;
    for (int o = 0; o < int'(RADIX); o++) begin
      grant[o*RADIX +: RADIX]           = grant_q[o];
      grant_valid[o]                    = |grant_q[o];
      grant_idx[o*IDX_WIDTH +: IDX_WIDTH] = idx_q[o];
    end
  end

  assign dest_err = dest_err_q;

endmodule

// File: tb/tb_switch_crossbar_sched.sv
// Directed self-checking bench for switch_crossbar_sched (RADIX=4, TIMEOUT=8).
module tb_switch_crossbar_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_valid = '0;
  logic [15:0] s_dest = '0;
  logic [3:0]  s_ready = '0;
  logic [3:0]  s_last = '0;
  logic [15:0] grant;
  logic [3:0]  grant_valid;
  logic [7:0]  grant_idx;
  logic [3:0]  dest_err;
  logic [3:0]  timeout;

  int checks = 0;
  int failures = 0;

  switch_crossbar_sched #(
    .RADIX   (4),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_dest      (s_dest),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .dest_err    (dest_err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid = '0;
    s_dest  = '0;
    s_ready = '0;
    s_last  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 16'h0) begin
      failures++;
      $display("FAIL reset_hold grant=%h expected=%h", grant, 16'h0);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 16'h0 || grant_valid !== 4'h0 || grant_idx !== 8'h0) begin
        failures++;
        $display("FAIL reset_idle c%0d grant=%h valid=%b idx=%h expected all zero",
                 c, grant, grant_valid, grant_idx);
      end
      checks++;
      if (dest_err !== 4'h0 || timeout !== 4'h0) begin
        failures++;
        $display("FAIL reset_pulses c%0d dest_err=%b timeout=%b expected 0", c, dest_err, timeout);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_grant();
    s_valid = 4'b0100;
    s_dest  = 16'h0100;
    s_ready = 4'b0000;
    s_last  = 4'b0000;
    @(negedge clk);
    checks++;
    if (grant !== 16'h0) begin
      failures++;
      $display("FAIL single_latency grant=%h expected=%h", grant, 16'h0);
    end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      s_ready = 4'b0100;
      s_last  = (k == 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      checks++;
      if (grant !== 16'h0004 || grant_idx !== 8'h02 || grant_valid !== 4'b0001) begin
        failures++;
        $display("FAIL single_locked beat%0d grant=%h idx=%h valid=%b expected 0004/02/0001",
                 k, grant, grant_idx, grant_valid);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (grant !== 16'h0 || grant_valid !== 4'h0) begin
      failures++;
      $display("FAIL single_release grant=%h valid=%b expected 0", grant, grant_valid);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int seq[3] = '{0, 1, 3};
    logic [1:0] exp;
    s_valid = 4'b1011;
    s_dest  = 16'h2022;
    s_ready = '0;
    s_last  = '0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 4'h0) begin
      failures++;
      $display("FAIL rr_latency valid=%b expected 0000", grant_valid);
    end
    next_cycle();
    for (int k = 0; k < 12; k++) begin
      exp     = 2'(seq[(k / 2) % 3]);
      s_ready = 4'b0001 << exp;
      s_last  = (k % 2 == 1) ? (4'b0001 << exp) : 4'b0000;
      if (k == 11) s_valid = 4'b1000;
      @(negedge clk);
      checks++;
      if (grant_idx[3:2] !== exp || grant_valid !== 4'b0010) begin
        failures++;
        $display("FAIL rr_order k%0d idx1=%0d valid=%b expected idx1=%0d valid=0010",
                 k, grant_idx[3:2], grant_valid, exp);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (grant_valid !== 4'h0) begin
      failures++;
      $display("FAIL rr_drain valid=%b expected 0000", grant_valid);
    end
    next_cycle();
  endtask

  task automatic test_parallel();
    s_valid = 4'b0111;
    s_dest  = 16'h0484;
    s_ready = '0;
    s_last  = '0;
    @(negedge clk);
    checks++;
    if (grant !== 16'h0) begin
      failures++;
      $display("FAIL par_latency grant=%h expected 0000", grant);
    end
    next_cycle();
    s_ready = 4'b0011;
    s_last  = 4'b0011;
    @(negedge clk);
    checks++;
    if (grant !== 16'h2100 || grant_idx !== 8'h40) begin
      failures++;
      $display("FAIL par_both grant=%h idx=%h expected 2100/40", grant, grant_idx);
    end
    next_cycle();
    s_valid = 4'b0100;
    s_ready = 4'b0100;
    s_last  = 4'b0100;
    @(negedge clk);
    checks++;
    if (grant !== 16'h0400 || grant_idx !== 8'h20 || grant_valid !== 4'b0100) begin
      failures++;
      $display("FAIL par_second grant=%h idx=%h valid=%b expected 0400/20/0100",
               grant, grant_idx, grant_valid);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (grant !== 16'h0) begin
      failures++;
      $display("FAIL par_drain grant=%h expected 0000", grant);
    end
    next_cycle();
  endtask

  task automatic test_exclusive();
    s_valid = 4'b0001;
    s_dest  = 16'h0001;
    s_ready = '0;
    s_last  = '0;
    next_cycle();
    // Mid-packet dest change to output 1 must not steal the locked input.
    s_dest = 16'h0002;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 16'h0001) begin
        failures++;
        $display("FAIL excl_mask c%0d grant=%h expected 0001", c, grant);
      end
      next_cycle();
    end
    s_ready = 4'b0001;
    s_last  = 4'b0001;
    @(negedge clk);
    checks++;
    if (grant !== 16'h0001) begin
      failures++;
      $display("FAIL excl_last grant=%h expected 0001", grant);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (grant !== 16'h0010 || grant_valid !== 4'b0010 || grant_idx !== 8'h00) begin
      failures++;
      $display("FAIL excl_handover grant=%h valid=%b idx=%h expected 0010/0010/00",
               grant, grant_valid, grant_idx);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (grant !== 16'h0) begin
      failures++;
      $display("FAIL excl_drain grant=%h expected 0000", grant);
    end
    next_cycle();
  endtask

  task automatic test_dest_err();
    logic [3:0] exp;
    s_valid = 4'b0110;
    s_dest  = 16'h0060;
    s_ready = 4'b1111;
    s_last  = '0;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) idle_inputs();
      exp = (c >= 1 && c <= 3) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      checks++;
      if (dest_err !== exp) begin
        failures++;
        $display("FAIL dest_err c%0d got=%b expected=%b", c, dest_err, exp);
      end
      checks++;
      if (grant !== 16'h0) begin
        failures++;
        $display("FAIL dest_err_nogrant c%0d grant=%h expected 0000", c, grant);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_v;
    logic [3:0] exp_t;
    s_valid = 4'b0010;
    s_dest  = 16'h0080;
    s_ready = '0;
    s_last  = '0;
    next_cycle();
    for (int c = 1; c <= 10; c++) begin
      if (c == 9) s_valid = 4'b0000;
`ifdef SWITCH_SCHED_TIMEOUT_EN
      exp_v = (c <= 8) ? 4'b1000 : 4'b0000;
      exp_t = (c == 9) ? 4'b1000 : 4'b0000;
`else
      exp_v = 4'b1000;
      exp_t = 4'b0000;
`endif
      @(negedge clk);
      checks++;
      if (grant_valid !== exp_v || timeout !== exp_t) begin
        failures++;
        $display("FAIL timeout c%0d valid=%b timeout=%b expected valid=%b timeout=%b",
                 c, grant_valid, timeout, exp_v, exp_t);
      end
      next_cycle();
    end
`ifndef SWITCH_SCHED_TIMEOUT_EN
    s_valid = 4'b0010;
    s_ready = 4'b0010;
    s_last  = 4'b0010;
    next_cycle();
`endif
    idle_inputs();
    @(negedge clk);
    checks++;
    if (grant !== 16'h0) begin
      failures++;
      $display("FAIL timeout_drain grant=%h expected 0000", grant);
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    s_valid = 4'b1000;
    s_dest  = 16'h1000;
    s_ready = '0;
    s_last  = '0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (grant !== 16'h0008 || grant_idx !== 8'h03) begin
      failures++;
      $display("FAIL async_pre grant=%h idx=%h expected 0008/03", grant, grant_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 16'h0 || grant_valid !== 4'h0 || grant_idx !== 8'h0) begin
      failures++;
      $display("FAIL async_clear grant=%h valid=%b idx=%h expected all zero",
               grant, grant_valid, grant_idx);
    end
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 16'h0) begin
      failures++;
      $display("FAIL async_after grant=%h expected 0000", grant);
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_parallel();
    test_exclusive();
    test_dest_err();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
